// File: rtl/sdram_arbit_if.sv
// Bundle between the SDRAM command arbiter and its sub-blocks / SDRAM pins.
// slave: arbiter side (takes requests, drives grants and pins); master: the rest.
interface sdram_arbit_if #(
   parameter int ADDR_W = 12,
   parameter int BANK_W = 2
);
   logic              flag_init_end;
   logic [3:0]        init_cmd;
   logic [ADDR_W-1:0] init_addr;

   logic              ref_req;
   logic              flag_ref_end;
   logic [3:0]        aref_cmd;
   logic [ADDR_W-1:0] aref_addr;
   logic              ref_en;

   logic              wr_req;
   logic              flag_wr_end;
   logic [3:0]        wr_cmd;
   logic [ADDR_W-1:0] wr_addr;
   logic [BANK_W-1:0] wr_bank;
   logic              wr_en;

   logic              rd_req;
   logic              flag_rd_end;
   logic [3:0]        rd_cmd;
   logic [ADDR_W-1:0] rd_addr;
   logic [BANK_W-1:0] rd_bank;
   logic              rd_en;

   logic              sdram_cke;
   logic              sdram_cs_n;
   logic              sdram_ras_n;
   logic              sdram_cas_n;
   logic              sdram_we_n;
   logic [ADDR_W-1:0] sdram_addr;
   logic [BANK_W-1:0] sdram_bank;

   modport slave (
      input  flag_init_end, init_cmd, init_addr,
      input  ref_req, flag_ref_end, aref_cmd, aref_addr,
      input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
      input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
      output ref_en, wr_en, rd_en,
      output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      output sdram_addr, sdram_bank
   );

   modport master (
      output flag_init_end, init_cmd, init_addr,
      output ref_req, flag_ref_end, aref_cmd, aref_addr,
      output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
      output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
      input  ref_en, wr_en, rd_en,
      input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      input  sdram_addr, sdram_bank
   );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: holds the bus for init, then grants refresh > write > read
// one at a time and muxes the owner's cmd/addr/bank onto the SDRAM pins.
// Ports: sclk, s_rst_n (async active-low), bus (sdram_arbit_if.slave).
// Optional macro ARBIT_RR_EN: write/read alternate round-robin instead of write > read.
module sdram_arbit #(
   parameter logic [3:0] CMD_NOP = 4'b0111,
   parameter int         ADDR_W  = 12,
   parameter int         BANK_W  = 2
) (
   input  logic         sclk,
   input  logic         s_rst_n,
   sdram_arbit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      ARBIT,
      AREF,
      WRITE,
      READ
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              sel_wr;
   logic              ref_en;
   logic              wr_en;
   logic              rd_en;
   logic              cke;
   logic [3:0]        cmd;
   logic [ADDR_W-1:0] addr;
   logic [BANK_W-1:0] bank;

`ifdef ARBIT_RR_EN
   // 1 = read was served last, so write wins the next tie
   logic last_rd;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         last_rd <= 1'b1;
      end else if (state == ARBIT) begin
         if (state_nxt == WRITE) begin
            last_rd <= 1'b0;
         end else if (state_nxt == READ) begin
            last_rd <= 1'b1;
         end
      end
   end

   assign sel_wr = bus.wr_req && (!bus.rd_req || last_rd);
`else
   assign sel_wr = bus.wr_req;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.flag_init_end) state_nxt = ARBIT;
         end
         ARBIT: begin
            if (bus.ref_req) begin
               state_nxt = AREF;
            end else if (sel_wr) begin
               state_nxt = WRITE;
            end else if (bus.rd_req) begin
               state_nxt = READ;
            end
         end
         AREF: begin
            if (bus.flag_ref_end) state_nxt = ARBIT;
         end
         WRITE: begin
            if (bus.flag_wr_end) state_nxt = ARBIT;
         end
         READ: begin
            if (bus.flag_rd_end) state_nxt = ARBIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grants fire on the transition out of ARBIT, so each is a one-cycle
   // pulse aligned with the first cycle of its owning state.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state  <= IDLE;
         ref_en <= 1'b0;
         wr_en  <= 1'b0;
         rd_en  <= 1'b0;
         cke    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cke    <= 1'b1;
         ref_en <= (state == ARBIT) && (state_nxt == AREF);
         wr_en  <= (state == ARBIT) && (state_nxt == WRITE);
         rd_en  <= (state == ARBIT) && (state_nxt == READ);
      end
   end

   always_comb begin
      cmd  = CMD_NOP;
      addr = '0;
      bank = '0;
      unique case (state)
         IDLE: begin
            cmd  = bus.init_cmd;
            addr = bus.init_addr;
         end
         AREF: begin
            cmd  = bus.aref_cmd;
            addr = bus.aref_addr;
         end
         WRITE: begin
            cmd  = bus.wr_cmd;
            addr = bus.wr_addr;
            bank = bus.wr_bank;
         end
         READ: begin
            cmd  = bus.rd_cmd;
            addr = bus.rd_addr;
            bank = bus.rd_bank;
         end
         default: begin
            cmd  = CMD_NOP;
         end
      endcase
   end

   assign bus.ref_en     = ref_en;
   assign bus.wr_en      = wr_en;
   assign bus.rd_en      = rd_en;
   assign bus.sdram_cke  = cke;
   assign {bus.sdram_cs_n, bus.sdram_ras_n,
           bus.sdram_cas_n, bus.sdram_we_n} = cmd;
   assign bus.sdram_addr = addr;
   assign bus.sdram_bank = bank;

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: ownership model checked every cycle plus
// directed scenarios with hand-computed grant order and latency.
module tb_sdram_arbit;

   localparam int O_INIT = 0;
   localparam int O_FREE = 1;
   localparam int O_REF  = 2;
   localparam int O_WR   = 3;
   localparam int O_RD   = 4;

   logic sclk = 1'b0;
   logic s_rst_n = 1'b0;
   always #5 sclk = ~sclk;

   sdram_arbit_if bus ();

   sdram_arbit dut (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .bus     (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gk[$];
   int gc[$];

   always @(posedge sclk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: who owns the bus, and whether ownership was just handed out.
   int m_own;
   bit m_fresh;
   bit m_cke;
   bit m_last_rd;

   function automatic bit wr_wins(bit w, bit r, bit last_rd);
`ifdef ARBIT_RR_EN
      if (w && r) return last_rd;
      return w;
`else
      return w;
`endif
   endfunction

   always @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         m_own     <= O_INIT;
         m_fresh   <= 1'b0;
         m_cke     <= 1'b0;
         m_last_rd <= 1'b1;
      end else begin
         m_cke   <= 1'b1;
         m_fresh <= 1'b0;
         case (m_own)
            O_INIT: if (bus.flag_init_end) m_own <= O_FREE;
            O_FREE: begin
               if (bus.ref_req) begin
                  m_own   <= O_REF;
                  m_fresh <= 1'b1;
               end else if (bus.wr_req || bus.rd_req) begin
                  m_fresh <= 1'b1;
                  if (wr_wins(bus.wr_req, bus.rd_req, m_last_rd)) begin
                     m_own     <= O_WR;
                     m_last_rd <= 1'b0;
                  end else begin
                     m_own     <= O_RD;
                     m_last_rd <= 1'b1;
                  end
               end
            end
            O_REF: if (bus.flag_ref_end) m_own <= O_FREE;
            O_WR:  if (bus.flag_wr_end) m_own <= O_FREE;
            O_RD:  if (bus.flag_rd_end) m_own <= O_FREE;
            default: m_own <= O_INIT;
         endcase
      end
   end

   logic [3:0]  e_cmd;
   logic [11:0] e_addr;
   logic [1:0]  e_bank;

   always @(negedge sclk) begin
      e_cmd  = 4'b0111;
      e_addr = '0;
      e_bank = '0;
      case (m_own)
         O_INIT: begin e_cmd = bus.init_cmd; e_addr = bus.init_addr; end
         O_REF:  begin e_cmd = bus.aref_cmd; e_addr = bus.aref_addr; end
         O_WR: begin
            e_cmd = bus.wr_cmd; e_addr = bus.wr_addr; e_bank = bus.wr_bank;
         end
         O_RD: begin
            e_cmd = bus.rd_cmd; e_addr = bus.rd_addr; e_bank = bus.rd_bank;
         end
         default: ;
      endcase
      check("cke", 32'(bus.sdram_cke), 32'(m_cke));
      check("ref_en", 32'(bus.ref_en), 32'(m_fresh && m_own == O_REF));
      check("wr_en", 32'(bus.wr_en), 32'(m_fresh && m_own == O_WR));
      check("rd_en", 32'(bus.rd_en), 32'(m_fresh && m_own == O_RD));
      check("cmd", 32'({bus.sdram_cs_n, bus.sdram_ras_n,
                        bus.sdram_cas_n, bus.sdram_we_n}), 32'(e_cmd));
      check("addr", 32'(bus.sdram_addr), 32'(e_addr));
      check("bank", 32'(bus.sdram_bank), 32'(e_bank));
      if (bus.ref_en) begin gk.push_back(1); gc.push_back(cyc); end
      if (bus.wr_en)  begin gk.push_back(2); gc.push_back(cyc); end
      if (bus.rd_en)  begin gk.push_back(3); gc.push_back(cyc); end
   end

   // Address/bank fields wander so the mux is exercised with varied data.
   initial begin
      forever begin
         @(negedge sclk);
         #2;
         bus.init_addr = 12'($urandom);
         bus.aref_addr = 12'($urandom);
         bus.wr_addr   = 12'($urandom);
         bus.rd_addr   = 12'($urandom);
         bus.wr_bank   = 2'($urandom);
         bus.rd_bank   = 2'($urandom);
      end
   end

   task automatic wait_grant(int budget);
      int  n0;
      bit  ok;
      n0 = gk.size();
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sclk);
         #1;
         if (gk.size() > n0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL grant_timeout: got none expected a grant within %0d cycles", budget);
      end
   endtask

   // Drive one end flag for one clock; returns the cycle it was raised in.
   task automatic pulse(int which, output int c);
      c = cyc;
      case (which)
         1: bus.flag_ref_end = 1'b1;
         2: bus.flag_wr_end  = 1'b1;
         default: bus.flag_rd_end = 1'b1;
      endcase
      @(posedge sclk);
      #1;
      bus.flag_ref_end = 1'b0;
      bus.flag_wr_end  = 1'b0;
      bus.flag_rd_end  = 1'b0;
   endtask

   int c0;
   int n;
   int kinds[4];
   int exp_k[4];

   initial begin
      bus.flag_init_end = 1'b0;
      bus.init_cmd = 4'h1;
      bus.aref_cmd = 4'h2;
      bus.wr_cmd   = 4'h4;
      bus.rd_cmd   = 4'h8;
      bus.init_addr = '0;
      bus.aref_addr = '0;
      bus.wr_addr = '0;
      bus.rd_addr = '0;
      bus.wr_bank = '0;
      bus.rd_bank = '0;
      bus.ref_req = 1'b0;
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.flag_ref_end = 1'b0;
      bus.flag_wr_end  = 1'b0;
      bus.flag_rd_end  = 1'b0;

      // reset state and CKE timing
      repeat (3) @(negedge sclk);
      check("cke_in_reset", 32'(bus.sdram_cke), 32'd0);
      #1 s_rst_n = 1'b1;
      @(posedge sclk);
      #1;
      check("cke_after_release", 32'(bus.sdram_cke), 32'd1);

      // 50 cycles without init_end: stays on init pins, no grants
      bus.ref_req = 1'b1;
      repeat (50) @(negedge sclk);
      check("idle_cmd", 32'({bus.sdram_cs_n, bus.sdram_ras_n,
                             bus.sdram_cas_n, bus.sdram_we_n}), 32'h1);
      check("idle_no_grant", 32'(gk.size()), 32'd0);

      // init done with refresh pending: ref_en two cycles later
      #1;
      bus.flag_init_end = 1'b1;
      c0 = cyc;
      wait_grant(8);
      check("t2_kind", 32'(gk[$]), 32'd1);
      check("t2_lat", 32'(gc[$] - c0), 32'd2);
      bus.ref_req = 1'b0;
      check("t2_aref_cmd", 32'({bus.sdram_cs_n, bus.sdram_ras_n,
                                bus.sdram_cas_n, bus.sdram_we_n}), 32'h2);
      repeat (3) @(negedge sclk);
      #1;
      pulse(1, c0);
      @(negedge sclk);
      check("t2_nop_cmd", 32'({bus.sdram_cs_n, bus.sdram_ras_n,
                               bus.sdram_cas_n, bus.sdram_we_n}), 32'h7);
      check("t2_nop_addr", 32'(bus.sdram_addr), 32'd0);
      #1;

      // all three requests: ref, then wr, then rd, each 2 cycles after end
      bus.ref_req = 1'b1;
      bus.wr_req  = 1'b1;
      bus.rd_req  = 1'b1;
      wait_grant(8);
      check("t3_first", 32'(gk[$]), 32'd1);
      bus.ref_req = 1'b0;
      repeat (2) @(negedge sclk);
      #1;
      pulse(1, c0);
      wait_grant(8);
      check("t3_second", 32'(gk[$]), 32'd2);
      check("t3_wr_gap", 32'(gc[$] - c0), 32'd2);
      bus.wr_req = 1'b0;
      repeat (2) @(negedge sclk);
      #1;
      pulse(2, c0);
      wait_grant(8);
      check("t3_third", 32'(gk[$]), 32'd3);
      check("t3_rd_gap", 32'(gc[$] - c0), 32'd2);
      bus.rd_req = 1'b0;
      repeat (2) @(negedge sclk);
      #1;
      pulse(3, c0);

      // write request during a read waits for the read to end
      bus.rd_req = 1'b1;
      wait_grant(8);
      check("t4_rd", 32'(gk[$]), 32'd3);
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b1;
      n = gk.size();
      repeat (5) @(negedge sclk);
      check("t4_no_preempt", 32'(gk.size()), 32'(n));
      #1;
      pulse(3, c0);
      wait_grant(8);
      check("t4_wr", 32'(gk[$]), 32'd2);
      check("t4_wr_gap", 32'(gc[$] - c0), 32'd2);
      bus.wr_req = 1'b0;
      repeat (2) @(negedge sclk);
      #1;
      pulse(2, c0);

      // reset in the grant cycle of a write
      bus.wr_req = 1'b1;
      wait_grant(8);
      check("t6_wr", 32'(gk[$]), 32'd2);
      bus.wr_req = 1'b0;
      s_rst_n = 1'b0;
      #1;
      check("t6_wr_en", 32'(bus.wr_en), 32'd0);
      check("t6_cke", 32'(bus.sdram_cke), 32'd0);
      check("t6_cmd", 32'({bus.sdram_cs_n, bus.sdram_ras_n,
                           bus.sdram_cas_n, bus.sdram_we_n}), 32'h1);
      repeat (2) @(negedge sclk);
      #1;
      s_rst_n = 1'b1;
      repeat (3) @(negedge sclk);
      #1;

      // write and read held together
`ifdef ARBIT_RR_EN
      exp_k = '{2, 3, 2, 3};
`else
      exp_k = '{2, 2, 2, 2};
`endif
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_grant(8);
         kinds[i] = gk[$];
         repeat (2) @(negedge sclk);
         #1;
         if (i == 3) begin
            bus.wr_req = 1'b0;
            bus.rd_req = 1'b0;
         end
         pulse(kinds[i], c0);
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t5_order%0d", i), 32'(kinds[i]), 32'(exp_k[i]));
      end

      repeat (5) @(negedge sclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
